// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, funct3 codes and size/sign helpers for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_RD = 3'd1,
    ST_WAIT_RD  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Access-size field is funct3[1:0]; funct3[2] selects zero-extension on loads.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic load_signed(input logic [2:0] funct3);
    return ~funct3[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational load extract/extend and sub-word store merge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [63:0] old_word,
  input  logic [63:0] new_data,
  output logic [63:0] load_data,
  output logic [63:0] merged_word
);

  logic [5:0]  w_shift;
  logic [63:0] w_shifted;
  logic [63:0] w_size_mask;
  logic [63:0] w_lane_mask;
  logic        w_sign;

  assign w_shift   = {lane, 3'b000};
  assign w_shifted = old_word >> w_shift;
  assign w_sign    = load_signed(funct3);

  always_comb begin
    load_data   = w_shifted;
    w_size_mask = '1;
    case (funct3[1:0])
      SZ_B: begin
        load_data   = {{56{w_sign & w_shifted[7]}}, w_shifted[7:0]};
        w_size_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_H: begin
        load_data   = {{48{w_sign & w_shifted[15]}}, w_shifted[15:0]};
        w_size_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_W: begin
        load_data   = {{32{w_sign & w_shifted[31]}}, w_shifted[31:0]};
        w_size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_data   = w_shifted;
        w_size_mask = '1;
      end
    endcase
  end

  // Only the addressed bytes of the old word are replaced.
  assign w_lane_mask = w_size_mask << w_shift;
  assign merged_word = (old_word & ~w_lane_mask) | ((new_data << w_shift) & w_lane_mask);

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV64 load/store initiator for a 64-bit word-granular data memory.
//            LSU_MISALIGN_CHECK_EN: misaligned accesses return an error
//            instead of being forced to natural alignment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [2:0]            req_funct3_in,
  input  logic [ADDR_WIDTH-1:0] req_address_in,
  input  logic [DATA_WIDTH-1:0] req_data_in,
  output logic                  resp_valid_out,
  output logic [DATA_WIDTH-1:0] resp_data_out,
  output logic                  resp_err_out,
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_writeEnable_out,
  output logic                  mem_readEnable_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  lsu_state_t            state, state_nxt;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_err;

  logic                  w_illegal;
  logic                  w_err;
  logic [2:0]            w_lowmask;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_illegal = req_write_in ? req_funct3_in[2] : (req_funct3_in == F3_LOAD_ILLEGAL);
  assign w_lowmask = 3'(size_bytes(req_funct3_in) - 4'd1);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_err      = w_illegal | (|(req_address_in[2:0] & w_lowmask));
  assign w_acc_addr = req_address_in;
`else
  assign w_err      = w_illegal;
  assign w_acc_addr = {req_address_in[ADDR_WIDTH-1:3], req_address_in[2:0] & ~w_lowmask};
`endif

  // r_wdata carries the raw store data until the read returns, then the merged word.
  lsu_lane_align u_lane_align (
    .lane        (r_addr[2:0]),
    .funct3      (r_funct3),
    .old_word    (mem_data_in),
    .new_data    (r_wdata),
    .load_data   (w_load_data),
    .merged_word (w_merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid_in) begin
          if (w_err)                                      state_nxt = ST_RESP;
          else if (req_write_in && req_funct3_in[1:0] == SZ_D) state_nxt = ST_WRITE;
          else                                            state_nxt = ST_ISSUE_RD;
        end
      end
      ST_ISSUE_RD: state_nxt = ST_WAIT_RD;
      ST_WAIT_RD:  state_nxt = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE:    state_nxt = ST_RESP;
      ST_RESP:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state       <= ST_IDLE;
      r_write     <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid_in) begin
            r_write     <= req_write_in;
            r_funct3    <= req_funct3_in;
            r_addr      <= w_acc_addr;
            r_wdata     <= req_data_in;
            r_resp_data <= '0;
            r_err       <= w_err;
          end
        end
        ST_WAIT_RD: begin
          if (r_write) r_wdata     <= w_merged;
          else         r_resp_data <= w_load_data;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_out       = (state == ST_IDLE);
  assign resp_valid_out      = (state == ST_RESP);
  assign resp_data_out       = r_resp_data;
  assign resp_err_out        = r_err;
  assign mem_address_out     = {r_addr[ADDR_WIDTH-1:3], 3'b000};
  assign mem_data_out        = r_wdata;
  assign mem_readEnable_out  = (state == ST_ISSUE_RD);
  assign mem_writeEnable_out = (state == ST_WRITE) & ~reset_in;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed scoreboard bench for load_store_unit with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [2:0]  req_funct3_in;
  logic [63:0] req_address_in;
  logic [63:0] req_data_in;
  logic        resp_valid_out;
  logic [63:0] resp_data_out;
  logic        resp_err_out;
  logic [63:0] mem_address_out;
  logic [63:0] mem_data_out;
  logic        mem_writeEnable_out;
  logic        mem_readEnable_out;
  logic [63:0] mem_data_in;

  load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .req_valid_in        (req_valid_in),
    .req_ready_out       (req_ready_out),
    .req_write_in        (req_write_in),
    .req_funct3_in       (req_funct3_in),
    .req_address_in      (req_address_in),
    .req_data_in         (req_data_in),
    .resp_valid_out      (resp_valid_out),
    .resp_data_out       (resp_data_out),
    .resp_err_out        (resp_err_out),
    .mem_address_out     (mem_address_out),
    .mem_data_out        (mem_data_out),
    .mem_writeEnable_out (mem_writeEnable_out),
    .mem_readEnable_out  (mem_readEnable_out),
    .mem_data_in         (mem_data_in)
  );

  always #5 clk_in = ~clk_in;

  // Word-granular memory: read data appears the cycle after the read-address edge.
  logic [63:0] mem [0:31];
  int          wr_count = 0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic [63:0] last_rd_addr = '0;

  always @(posedge clk_in) begin
    if (mem_writeEnable_out) begin
      mem[mem_address_out[7:3]] <= mem_data_out;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address_out;
      last_wr_data <= mem_data_out;
    end
    if (mem_readEnable_out) begin
      mem_data_in  <= mem[mem_address_out[7:3]];
      last_rd_addr <= mem_address_out;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_ready"}, 64'(req_ready_out), 64'd1);
  endtask

  // Drive one request at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] ed, input logic ee, input int lat, input string tag);
    exp_t e;
    wait_ready(tag);
    e.data = ed; e.err = ee; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    req_valid_in   = 1'b1;
    req_write_in   = w;
    req_funct3_in  = f3;
    req_address_in = a;
    req_data_in    = d;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (sample point E0+1).
  task automatic wait_resp();
    exp_t e;
    bit   got = 0;
    bit   en_seen = 0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    for (int k = 1; k <= 10 && !got; k++) begin
      if (resp_valid_out) begin
        got = 1;
        chk({e.tag, "_lat"}, 64'(k), 64'(e.lat));
        chk({e.tag, "_data"}, resp_data_out, e.data);
        chk({e.tag, "_err"}, 64'(resp_err_out), 64'(e.err));
        chk({e.tag, "_resp_en"}, 64'({mem_readEnable_out, mem_writeEnable_out}), 64'd0);
      end else begin
        en_seen |= mem_readEnable_out | mem_writeEnable_out;
        chk({e.tag, "_busy"}, 64'(req_ready_out), 64'd0);
        @(negedge clk_in);
      end
    end
    if (!got) chk({e.tag, "_timeout"}, 64'd0, 64'd1);
    if (e.err) chk({e.tag, "_no_mem"}, 64'(en_seen), 64'd0);
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] ed, input logic ee, input int lat, input string tag);
    send(w, f3, a, d, ed, ee, lat, tag);
    wait_resp();
  endtask

  initial begin
    int wc;
    reset_in       = 1'b1;
    req_valid_in   = 1'b0;
    req_write_in   = 1'b0;
    req_funct3_in  = '0;
    req_address_in = '0;
    req_data_in    = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;

    chk("rst_ready", 64'(req_ready_out), 64'd1);
    chk("rst_valid", 64'(resp_valid_out), 64'd0);
    chk("rst_data", resp_data_out, 64'd0);
    chk("rst_err", 64'(resp_err_out), 64'd0);
    chk("rst_en", 64'({mem_readEnable_out, mem_writeEnable_out}), 64'd0);
    chk("rst_maddr", mem_address_out, 64'd0);
    chk("rst_mdata", mem_data_out, 64'd0);

    txn(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 2, "sd10");
    chk("sd10_wcount", 64'(wr_count), 64'd1);
    chk("sd10_waddr", last_wr_addr, 64'h10);
    chk("sd10_wdata", last_wr_data, 64'h1122334455667788);
    txn(1'b0, 3'b011, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 3, "ld10");
    chk("ld10_raddr", last_rd_addr, 64'h10);

    txn(1'b1, 3'b000, 64'h13, 64'h123456789ABCDEAB, 64'd0, 1'b0, 4, "sb13");
    chk("sb13_raddr", last_rd_addr, 64'h10);
    chk("sb13_waddr", last_wr_addr, 64'h10);
    chk("sb13_wdata", last_wr_data, 64'h11223344AB667788);
    txn(1'b0, 3'b000, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 3, "lb13");
    txn(1'b0, 3'b100, 64'h13, 64'd0, 64'h00000000000000AB, 1'b0, 3, "lbu13");

    txn(1'b1, 3'b001, 64'h16, 64'h00000000CAFEBEEF, 64'd0, 1'b0, 4, "sh16");
    chk("sh16_wdata", last_wr_data, 64'hBEEF3344AB667788);
    txn(1'b0, 3'b001, 64'h16, 64'd0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 3, "lh16");
    txn(1'b0, 3'b010, 64'h10, 64'd0, 64'hFFFFFFFFAB667788, 1'b0, 3, "lw10");
    txn(1'b0, 3'b110, 64'h10, 64'd0, 64'h00000000AB667788, 1'b0, 3, "lwu10");

`ifdef LSU_MISALIGN_CHECK_EN
    txn(1'b0, 3'b010, 64'h12, 64'd0, 64'd0, 1'b1, 1, "lw12_mis");
`else
    txn(1'b0, 3'b010, 64'h12, 64'd0, 64'hFFFFFFFFAB667788, 1'b0, 3, "lw12_align");
`endif
    txn(1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b1, 1, "ld_f3_111");
    wc = wr_count;
    txn(1'b1, 3'b100, 64'h10, 64'hFF, 64'd0, 1'b1, 1, "st_f3_100");
    chk("st_f3_100_wcount", 64'(wr_count), 64'(wc));

    // Reset during the WRITE cycle of SB 0x10 must suppress the write and the response.
    send(1'b1, 3'b000, 64'h10, 64'h00, 64'd0, 1'b0, 4, "sb_rst");
    void'(sb.pop_back());
    chk("sb_rst_issue", 64'(mem_readEnable_out), 64'd1);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("sb_rst_write_state", 64'(mem_writeEnable_out), 64'd1);
    wc = wr_count;
    reset_in = 1'b1;
    #1;
    chk("sb_rst_we_gated", 64'(mem_writeEnable_out), 64'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    chk("sb_rst_ready", 64'(req_ready_out), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sb_rst_no_resp", 64'(resp_valid_out), 64'd0);
      @(negedge clk_in);
    end
    chk("sb_rst_wcount", 64'(wr_count), 64'(wc));
    txn(1'b0, 3'b011, 64'h10, 64'd0, 64'hBEEF3344AB667788, 1'b0, 3, "ld10_after_rst");

    // Second request held valid while a store is in flight.
    send(1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF, 64'd0, 1'b0, 2, "busy_sd");
    req_valid_in   = 1'b1;
    req_write_in   = 1'b0;
    req_funct3_in  = 3'b011;
    req_address_in = 64'h18;
    req_data_in    = '0;
    sb.push_back('{data: 64'h0123456789ABCDEF, err: 1'b0, lat: 3, tag: "busy_ld"});
    wait_resp();
    chk("busy_sd_waddr", last_wr_addr, 64'h18);
    @(negedge clk_in);
    chk("busy_ld_ready", 64'(req_ready_out), 64'd1);
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    wait_resp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
